// File: rtl/cmp_pipe_unit.sv
// cmp_pipe_unit: two-stage compare/min/max/absdiff pipeline with a saturating
// match counter and a running maximum.
//   CLK         - clock, all state updates on the rising edge
//   RST         - synchronous active-high reset, highest priority
//   CMP_Enable  - issue strobe for ALU_FUN/A/B/SIGNED_MODE
//   ALU_FUN     - operation select (NOP, EQ, GT, LT, MAX, MIN, RUN_MAX, ABSDIFF)
//   SIGNED_MODE - 1: operands and running max are two's complement
//   A, B        - operands
//   CLR_STATS   - clears match counter, saturation flag and running max
//   CMP_OUT     - registered result, zero when CMP_Flag is low
//   CMP_Flag    - CMP_OUT valid, two cycles after the accepted issue
//   MATCH_CNT   - saturating count of true EQ/GT/LT results
//   CNT_SAT     - sticky: MATCH_CNT saturated
module cmp_pipe_unit #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CMP_Enable,
    input  logic [2:0]           ALU_FUN,
    input  logic                 SIGNED_MODE,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 CLR_STATS,
    output logic [WIDTH-1:0]     CMP_OUT,
    output logic                 CMP_Flag,
    output logic [CNT_WIDTH-1:0] MATCH_CNT,
    output logic                 CNT_SAT
);

    localparam logic [2:0] FUN_NOP     = 3'b000;
    localparam logic [2:0] FUN_EQ      = 3'b001;
    localparam logic [2:0] FUN_GT      = 3'b010;
    localparam logic [2:0] FUN_LT      = 3'b011;
    localparam logic [2:0] FUN_MAX     = 3'b100;
    localparam logic [2:0] FUN_MIN     = 3'b101;
    localparam logic [2:0] FUN_RUN_MAX = 3'b110;
    localparam logic [2:0] FUN_ABSDIFF = 3'b111;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Stage-1 operation registers
    logic             s1_valid;
    logic [2:0]       s1_fun;
    logic             s1_signed;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    // Running-max state
    logic [WIDTH-1:0] run_max;
    logic             run_max_vld;

    // Stage-2 combinational results
    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;
    logic [WIDTH-1:0] rm_key;
    logic             a_gt_b;
    logic             a_lt_b;
    logic             rm_load;
    logic             is_match;
    logic [WIDTH-1:0] result;

    // Flipping the MSB in signed mode maps two's complement order onto unsigned order
    always_comb begin
        a_key    = {s1_a[WIDTH-1] ^ s1_signed, s1_a[WIDTH-2:0]};
        b_key    = {s1_b[WIDTH-1] ^ s1_signed, s1_b[WIDTH-2:0]};
        rm_key   = {run_max[WIDTH-1] ^ s1_signed, run_max[WIDTH-2:0]};
        a_gt_b   = a_key > b_key;
        a_lt_b   = a_key < b_key;
        rm_load  = (s1_fun == FUN_RUN_MAX) && (!run_max_vld || (a_key > rm_key));
        result   = '0;
        is_match = 1'b0;
        case (s1_fun)
            FUN_NOP: result = '0;
            FUN_EQ: begin
                is_match = (s1_a == s1_b);
                result   = is_match ? WIDTH'(1) : '0;
            end
            FUN_GT: begin
                is_match = a_gt_b;
                result   = a_gt_b ? WIDTH'(2) : '0;
            end
            FUN_LT: begin
                is_match = a_lt_b;
                result   = a_lt_b ? WIDTH'(3) : '0;
            end
            FUN_MAX:     result = a_lt_b ? s1_b : s1_a;
            FUN_MIN:     result = a_gt_b ? s1_b : s1_a;
            FUN_RUN_MAX: result = rm_load ? s1_a : run_max;
            // Modular subtraction of the larger minus smaller always fits WIDTH bits
            FUN_ABSDIFF: result = a_gt_b ? (s1_a - s1_b) : (s1_b - s1_a);
            default:     result = '0;
        endcase
    end

    // Pipeline registers, outputs and statistics
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid    <= 1'b0;
            s1_fun      <= FUN_NOP;
            s1_signed   <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            CMP_OUT     <= '0;
            CMP_Flag    <= 1'b0;
            MATCH_CNT   <= '0;
            CNT_SAT     <= 1'b0;
            run_max     <= '0;
            run_max_vld <= 1'b0;
        end else begin
            s1_valid  <= CMP_Enable;
            s1_fun    <= ALU_FUN;
            s1_signed <= SIGNED_MODE;
            s1_a      <= A;
            s1_b      <= B;
            CMP_Flag  <= s1_valid;
            CMP_OUT   <= s1_valid ? result : '0;

            // A clear discards any same-cycle update; the result above still uses pre-clear state
            if (CLR_STATS) begin
                MATCH_CNT   <= '0;
                CNT_SAT     <= 1'b0;
                run_max     <= '0;
                run_max_vld <= 1'b0;
            end else if (s1_valid) begin
                if (rm_load) begin
                    run_max     <= s1_a;
                    run_max_vld <= 1'b1;
                end
                if (is_match) begin
                    if (MATCH_CNT == CNT_MAX) begin
                        CNT_SAT <= 1'b1;
                    end else begin
                        MATCH_CNT <= MATCH_CNT + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: doc/cmp_pipe_unit.md
CMP_PIPE_UNIT -- requirements
Module: cmp_pipe_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (>=2).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, meaning match-counter width in bits (>=2).
REQ-003 SHALL have port CLK  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port CMP_Enable  input  1  meaning issue strobe: the operation on ALU_FUN/A/B/SIGNED_MODE is accepted this cycle.
REQ-006 SHALL have port ALU_FUN  input  3  meaning operation select.
REQ-007 SHALL have port SIGNED_MODE  input  1  meaning 1 = A, B and the running max are two's complement; 0 = unsigned.
REQ-008 SHALL have ports A and B  input  WIDTH  meaning the operands.
REQ-009 SHALL have port CLR_STATS  input  1  meaning clear the match counter, saturation flag and running max.
REQ-010 SHALL have port CMP_OUT  output  WIDTH  meaning the registered result.
REQ-011 SHALL have port CMP_Flag  output  1  meaning CMP_OUT holds a valid result this cycle.
REQ-012 SHALL have port MATCH_CNT  output  CNT_WIDTH  meaning the count of true compare results.
REQ-013 SHALL have port CNT_SAT  output  1  meaning sticky flag: MATCH_CNT has saturated.

Function
REQ-014 SHALL be a 2-stage pipeline: stage 1 registers the accepted operands, function and mode, and stage 2 computes and registers CMP_OUT.
REQ-015 SHALL assert CMP_Flag exactly 2 cycles after CMP_Enable is sampled high, for one cycle per accepted operation, with throughput of 1 operation per cycle and no backpressure.
REQ-016 SHALL drive CMP_OUT = 0 and CMP_Flag = 0 in every cycle without a valid result.
REQ-017 SHALL implement ALU_FUN 000 NOP: result 0, CMP_Flag still asserted.
REQ-018 SHALL implement ALU_FUN 001 EQ: result 1 if A==B, else 0.
REQ-019 SHALL implement ALU_FUN 010 GT: result 2 if A>B, else 0.
REQ-020 SHALL implement ALU_FUN 011 LT: result 3 if A<B, else 0.
REQ-021 SHALL implement ALU_FUN 100 MAX and 101 MIN: result is the larger or smaller of A and B, respectively.
REQ-022 SHALL implement ALU_FUN 110 RUN_MAX: if the running max is not valid, or A > the running max, the running max is loaded with A and marked valid; result is the updated running max; B is ignored.
REQ-023 SHALL implement ALU_FUN 111 ABSDIFF: result |A-B| as an unsigned WIDTH-bit value, which cannot overflow in either mode.
REQ-024 SHALL evaluate every ordering in REQ-019..REQ-023 according to the SIGNED_MODE captured with that operation; RUN_MAX compares the stored value in that same mode.
REQ-025 SHALL increment MATCH_CNT by 1 in the stage-2 cycle of any EQ, GT or LT operation whose result is nonzero.
REQ-026 SHALL hold MATCH_CNT at 2^CNT_WIDTH-1 once it reaches that value, and set CNT_SAT on the first increment attempted at that value.
REQ-027 SHALL keep CNT_SAT set until RST or CLR_STATS.
REQ-028 SHALL, when CLR_STATS is high, set MATCH_CNT to 0, CNT_SAT to 0 and the running-max valid bit to 0 on the next edge.
REQ-029 SHALL give CLR_STATS priority over a same-cycle stage-2 counter increment or running-max update, discarding that update.
REQ-030 SHALL still present, with CMP_Flag, the CMP_OUT of an operation whose update REQ-029 discards, computed from the pre-clear state.
REQ-031 SHALL have back-to-back RUN_MAX operations see the update of the previous one, with no hazard bubble.

Reset
REQ-032 SHALL, when RST is high at an edge, clear both pipeline valid bits, CMP_OUT, CMP_Flag, MATCH_CNT, CNT_SAT and the running-max valid bit to 0; this sync reset takes priority over all other inputs.
REQ-033 SHALL, when RST is asserted mid-operation, drop in-flight operations so that no CMP_Flag pulse emerges for them after RST deasserts.
REQ-034 SHALL accept a CMP_Enable asserted in the first cycle after RST deasserts and deliver its result 2 cycles later.

Verification
REQ-035 SHALL cover latency: WIDTH=8, GT with A=9, B=4 at cycle 0 -> CMP_Flag=1 and CMP_OUT=2 at cycle 2 only; CMP_OUT=0 at cycles 1 and 3.
REQ-036 SHALL cover signed mode: A=8'hFF, B=8'h01, LT with SIGNED_MODE=1 -> 3; same operands with SIGNED_MODE=0 -> 0; ABSDIFF with SIGNED_MODE=1 -> 2.
REQ-037 SHALL cover running max: RUN_MAX back-to-back with A=5, 3, 7, 7 (unsigned) -> CMP_OUT 5, 5, 7, 7 on consecutive cycles; then CLR_STATS; then RUN_MAX A=2 -> 2.
REQ-038 SHALL cover saturation: CNT_WIDTH=2, five EQ matches -> MATCH_CNT 1, 2, 3, 3, 3 and CNT_SAT=1 after the fourth match; CLR_STATS in the cycle of a match -> MATCH_CNT=0, CNT_SAT=0.
REQ-039 SHALL cover reset mid-flight: issue MAX A=3, B=6, then assert RST for 1 cycle -> no CMP_Flag pulse afterwards and all outputs 0.
REQ-040 SHALL cover streaming: 100 random back-to-back operations in both modes -> every result matches the reference model with exactly 2 cycles of latency.
